// File: rtl/uart_pkg.sv
// uart_pkg
// Shared types and elaboration helpers for the UART transmit path.
//   uart_tx_state_e : transmit sequencer states
//   calc_phase_inc  : phase-accumulator increment for a given clock/baud pair
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_e;

    // floor(baud * 2^width / sys_clk). The product is formed in 64 bits
    // so a 32-bit accumulator at high baud rates cannot overflow.
    function automatic longint calc_phase_inc(input longint sys_clk,
                                              input longint baud,
                                              input int     width);
        return (baud << width) / sys_clk;
    endfunction

endpackage

// File: rtl/uart_tx_sequencer_baud_tick_gen.sv
// baud_tick_gen
// Phase-accumulator baud timebase. While enabled the accumulator adds
// PHASE_INC every cycle; the carry out of the add is the bit tick. The
// accumulator wraps and keeps its residue, so the fractional clocks-per-bit
// ratio is honoured over a whole frame without drift.
// Ports:
//   clk    : system clock
//   reset  : synchronous reset, active-high (clears accumulator)
//   clear  : synchronous clear, used at the start of each frame
//   enable : accumulate this cycle
//   tick   : one-cycle pulse on accumulator carry-out
module baud_tick_gen #(
    parameter int                   ACC_WIDTH = 32,
    parameter logic [ACC_WIDTH-1:0] PHASE_INC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH:0]   sum;

    assign sum  = {1'b0, acc_q} + {1'b0, PHASE_INC};
    assign tick = enable & sum[ACC_WIDTH];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= sum[ACC_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// UART transmit controller: start bit, DATA_BITS data bits LSB-first,
// optional parity, STOP_BITS stop bits, paced by a phase-accumulator tick.
// Ports:
//   clk        : system clock
//   reset      : synchronous reset, active-high
//   tx_data    : word to send, captured on accept
//   tx_valid   : upstream has a word
//   tx_ready   : sequencer can accept (IDLE and not in reset)
//   tx         : serial line, idle-high, registered
//   busy       : frame in progress
//   frame_done : one-cycle pulse on the first IDLE cycle after the last stop bit
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | line high, waiting for tx_valid
// START  | driving start bit (0)
// DATA   | driving shift_q[0], bit_cnt_q counts bits sent
// PARITY | driving the precomputed parity bit
// STOP   | line high, stop_cnt_q counts stop bits
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 125000000,
    parameter int BAUD_RATE    = 115200,
    parameter int ACC_WIDTH    = 32,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam longint               PHASE_INC_L = calc_phase_inc(SYS_CLK_FREQ, BAUD_RATE, ACC_WIDTH);
    localparam logic [ACC_WIDTH-1:0] PHASE_INC   = PHASE_INC_L[ACC_WIDTH-1:0];

    // A bit must span at least two clocks, otherwise the carry could be
    // asserted on consecutive cycles and bits would be skipped.
    if (PHASE_INC_L == 0 || PHASE_INC_L >= (longint'(1) << (ACC_WIDTH - 1))) begin : g_bad_rate
        $error("uart_tx_sequencer: baud rate gives fewer than 2 clocks per bit or zero increment");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_sequencer: DATA_BITS must be 5..9");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("uart_tx_sequencer: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_e       state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 parity_q, parity_d;
    logic                 tx_d;
    logic                 frame_done_d;
    logic                 accept;
    logic                 tick;
    logic                 last_stop;

    assign tx_ready  = (state_q == IDLE) && !reset;
    assign accept    = tx_valid && tx_ready;
    assign busy      = (state_q != IDLE);
    assign last_stop = (STOP_BITS == 1) || stop_cnt_q;

    baud_tick_gen #(
        .ACC_WIDTH (ACC_WIDTH),
        .PHASE_INC (PHASE_INC)
    ) u_baud_tick_gen (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept),
        .enable (busy),
        .tick   (tick)
    );

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        stop_cnt_d   = stop_cnt_q;
        parity_d     = parity_q;
        frame_done_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = START;
                    shift_d  = tx_data;
                    parity_d = (^tx_data) ^ (PARITY_ODD != 0);
                end
            end
            START: begin
                if (tick) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
                        state_d    = (PARITY_EN != 0) ? PARITY : STOP;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d    = STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (last_stop) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the state being entered, so tx changes on the
        // same edge as the state register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            parity_q   <= 1'b0;
            tx         <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            parity_q   <= parity_d;
            tx         <= tx_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer
// Directed bench for uart_tx_sequencer. Four instances share clk/reset:
//   0: 16 Hz / 4 baud, 8N1         (4 clocks per bit)
//   1: 16 Hz / 4 baud, 8E2
//   2: 16 Hz / 4 baud, 8O1
//   3: default 125 MHz / 115200, 8N1
// Cycle index k counts samples taken 1 ns after each rising edge, with k=0
// right after the accept edge.
module tb_uart_tx_sequencer;

    logic       clk;
    logic       reset;
    logic [3:0] tx_valid_v;
    logic [7:0] tx_data_v [4];
    wire  [3:0] tx_w;
    wire  [3:0] busy_w;
    wire  [3:0] ready_w;
    wire  [3:0] done_w;

    int checks = 0;
    int errors = 0;

    logic [127:0] cap_bits;
    int           cap_done;
    int           cap_ready_hi;
    int           edge_t [16];
    int           n_edges;

    uart_tx_sequencer #(.SYS_CLK_FREQ(16), .BAUD_RATE(4)) u_a (
        .clk(clk), .reset(reset), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
        .tx_ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .frame_done(done_w[0]));

    uart_tx_sequencer #(.SYS_CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
        .clk(clk), .reset(reset), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
        .tx_ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .frame_done(done_w[1]));

    uart_tx_sequencer #(.SYS_CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .reset(reset), .tx_data(tx_data_v[2]), .tx_valid(tx_valid_v[2]),
        .tx_ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .frame_done(done_w[2]));

    uart_tx_sequencer u_d (
        .clk(clk), .reset(reset), .tx_data(tx_data_v[3]), .tx_valid(tx_valid_v[3]),
        .tx_ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]), .frame_done(done_w[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // seq[i] is the i-th bit on the line in time order; each lasts cpb clocks.
    function automatic logic [127:0] expand(input logic [15:0] seq, input int nbits, input int cpb);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < nbits * cpb; i++) r[i] = seq[i / cpb];
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offers one word, then samples tx until frame_done is seen or max_cyc.
    // Optionally pulses tx_valid with other data at cycle inj_k.
    task automatic run_frame(input int idx, input logic [7:0] data, input int max_cyc,
                             input int inj_k, input logic [7:0] inj_data);
        logic prev;
        cap_bits     = '0;
        cap_done     = -1;
        cap_ready_hi = 0;
        n_edges      = 0;
        prev         = 1'b0;
        tx_data_v[idx]  = data;
        tx_valid_v[idx] = 1'b1;
        step();
        tx_valid_v[idx] = 1'b0;
        for (int k = 0; k < max_cyc; k++) begin
            if (done_w[idx]) begin
                cap_done = k;
                break;
            end
            if (k < 128) cap_bits[k] = tx_w[idx];
            if (ready_w[idx]) cap_ready_hi++;
            if (k > 0 && tx_w[idx] !== prev && n_edges < 16) begin
                edge_t[n_edges] = k;
                n_edges++;
            end
            prev = tx_w[idx];
            if (k == inj_k) begin
                tx_data_v[idx]  = inj_data;
                tx_valid_v[idx] = 1'b1;
            end else if (k == inj_k + 1) begin
                tx_valid_v[idx] = 1'b0;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_valid_v = '0;
        for (int i = 0; i < 4; i++) tx_data_v[i] = 8'h00;
        repeat (3) step();
        checks++;
        if (tx_w !== 4'hF) begin errors++; $display("FAIL reset_tx got %b want 1111", tx_w); end
        checks++;
        if (busy_w !== 4'h0) begin errors++; $display("FAIL reset_busy got %b want 0000", busy_w); end
        checks++;
        if (done_w !== 4'h0) begin errors++; $display("FAIL reset_done got %b want 0000", done_w); end
        checks++;
        if (ready_w !== 4'h0) begin errors++; $display("FAIL reset_ready got %b want 0000", ready_w); end
        reset = 1'b0;
        #1;
        checks++;
        if (ready_w !== 4'hF) begin errors++; $display("FAIL idle_ready got %b want 1111", ready_w); end
        step();
    endtask

    task automatic test_basic_frame();
        // 0xA5 8N1: 0 | 1 0 1 0 0 1 0 1 | 1
        run_frame(0, 8'hA5, 200, -1, 8'h00);
        checks++;
        if (cap_done !== 40) begin errors++; $display("FAIL basic_done_at got %0d want 40", cap_done); end
        checks++;
        if (cap_bits !== expand(16'b1101001010, 10, 4)) begin
            errors++; $display("FAIL basic_bits got %h want %h", cap_bits, expand(16'b1101001010, 10, 4));
        end
        checks++;
        if (cap_ready_hi !== 0) begin errors++; $display("FAIL basic_ready_in_frame got %0d want 0", cap_ready_hi); end
        checks++;
        if ({tx_w[0], busy_w[0], ready_w[0]} !== 3'b101) begin
            errors++; $display("FAIL basic_done_cycle tx/busy/ready got %b want 101", {tx_w[0], busy_w[0], ready_w[0]});
        end
        step();
        checks++;
        if (done_w[0] !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done_w[0]); end
    endtask

    task automatic test_parity();
        // 0xA5 has four ones: even parity 0, odd parity 1.
        run_frame(1, 8'hA5, 200, -1, 8'h00);
        checks++;
        if (cap_done !== 48) begin errors++; $display("FAIL even2_done_at got %0d want 48", cap_done); end
        checks++;
        if (cap_bits !== expand(16'b110101001010, 12, 4)) begin
            errors++; $display("FAIL even2_bits got %h want %h", cap_bits, expand(16'b110101001010, 12, 4));
        end
        step();
        run_frame(2, 8'hA5, 200, -1, 8'h00);
        checks++;
        if (cap_done !== 44) begin errors++; $display("FAIL odd_done_at got %0d want 44", cap_done); end
        checks++;
        if (cap_bits !== expand(16'b11101001010, 11, 4)) begin
            errors++; $display("FAIL odd_bits got %h want %h", cap_bits, expand(16'b11101001010, 11, 4));
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [127:0] got;
        logic [127:0] exp;
        int d1;
        int d2;
        got = '0;
        exp = '0;
        d1  = -1;
        d2  = -1;
        // First frame 0x00: low k=0..35, stop k=36..39, idle k=40,
        // second frame 0xFF: start k=41..44, ones from k=45 onward.
        for (int k = 0; k < 96; k++) exp[k] = (k >= 36 && k <= 40) || (k >= 45);
        tx_data_v[0]  = 8'h00;
        tx_valid_v[0] = 1'b1;
        step();
        tx_data_v[0] = 8'hFF;
        for (int k = 0; k < 96; k++) begin
            if (done_w[0]) begin
                if (d1 < 0) d1 = k;
                else if (d2 < 0) d2 = k;
            end
            got[k] = tx_w[0];
            if (d1 >= 0 && k == d1 + 1) tx_valid_v[0] = 1'b0;
            step();
        end
        tx_valid_v[0] = 1'b0;
        checks++;
        if (d1 !== 40) begin errors++; $display("FAIL b2b_first_done got %0d want 40", d1); end
        checks++;
        if (d2 !== 81) begin errors++; $display("FAIL b2b_second_done got %0d want 81", d2); end
        checks++;
        if (got !== exp) begin errors++; $display("FAIL b2b_bits got %h want %h", got, exp); end
    endtask

    task automatic test_default_baud();
        int per;
        // 0x55 alternates every bit, so each bit boundary is a line edge.
        run_frame(3, 8'h55, 12000, -1, 8'h00);
        checks++;
        if (cap_done !== 10851) begin errors++; $display("FAIL dflt_frame_len got %0d want 10851", cap_done); end
        checks++;
        if (n_edges !== 9) begin errors++; $display("FAIL dflt_edges got %0d want 9", n_edges); end
        if (n_edges == 9) begin
            for (int i = 0; i < 10; i++) begin
                if (i == 0) per = edge_t[0];
                else if (i == 9) per = cap_done - edge_t[8];
                else per = edge_t[i] - edge_t[i-1];
                checks++;
                if (per != 1085 && per != 1086) begin
                    errors++; $display("FAIL dflt_bit%0d_period got %0d want 1085 or 1086", i, per);
                end
            end
        end
        step();
    endtask

    task automatic test_reset_mid_frame();
        int done_seen;
        done_seen = 0;
        tx_data_v[0]  = 8'hA5;
        tx_valid_v[0] = 1'b1;
        step();
        tx_valid_v[0] = 1'b0;
        repeat (17) step();
        // k=17 is inside data bit 3, which is 0 for 0xA5.
        checks++;
        if ({tx_w[0], busy_w[0]} !== 2'b01) begin
            errors++; $display("FAIL midrst_before tx/busy got %b want 01", {tx_w[0], busy_w[0]});
        end
        reset = 1'b1;
        step();
        checks++;
        if ({tx_w[0], busy_w[0], done_w[0]} !== 3'b100) begin
            errors++; $display("FAIL midrst_after tx/busy/done got %b want 100", {tx_w[0], busy_w[0], done_w[0]});
        end
        reset = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (done_w[0]) done_seen++;
            step();
        end
        checks++;
        if (done_seen !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", done_seen); end
        run_frame(0, 8'hA5, 200, -1, 8'h00);
        checks++;
        if (cap_done !== 40) begin errors++; $display("FAIL midrst_clean_done got %0d want 40", cap_done); end
        checks++;
        if (cap_bits !== expand(16'b1101001010, 10, 4)) begin
            errors++; $display("FAIL midrst_clean_bits got %h want %h", cap_bits, expand(16'b1101001010, 10, 4));
        end
        step();
    endtask

    task automatic test_ignore_midframe();
        // 0x3C: 0 | 0 0 1 1 1 1 0 0 | 1 ; a 0xC3 offer at k=10 must be dropped.
        run_frame(0, 8'h3C, 200, 10, 8'hC3);
        checks++;
        if (cap_done !== 40) begin errors++; $display("FAIL ignore_done_at got %0d want 40", cap_done); end
        checks++;
        if (cap_bits !== expand(16'b1001111000, 10, 4)) begin
            errors++; $display("FAIL ignore_bits got %h want %h", cap_bits, expand(16'b1001111000, 10, 4));
        end
        step();
        checks++;
        if (busy_w[0] !== 1'b0) begin errors++; $display("FAIL ignore_no_second_frame busy got %b want 0", busy_w[0]); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_frame();
        test_parity();
        test_back_to_back();
        test_default_baud();
        test_reset_mid_frame();
        test_ignore_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
UART transmit controller that sequences a phase-accumulator baud timebase into a complete serial frame: start bit, data bits LSB-first, optional parity, then stop bit(s). It accepts one byte at a time over a valid/ready handshake from upstream logic. It drives the serial `tx` line directly and sits beside the receive path in the UART subsystem.

Parameters:
SYS_CLK_FREQ  125000000  system clock frequency, Hz
BAUD_RATE  115200  serial bit rate, bit/s
ACC_WIDTH  32  phase accumulator width, bits
DATA_BITS  8  data bits per frame; legal range 5..9
PARITY_EN  0  1 = append a parity bit after the data
PARITY_ODD  0  when PARITY_EN=1: 0 = even parity, 1 = odd parity
STOP_BITS  1  stop-bit count; legal values 1 or 2

Ports:
clk  input  1  system clock
reset  input  1  synchronous reset, active-high
tx_data  input  DATA_BITS  byte to send; sampled on accept
tx_valid  input  1  upstream has data
tx_ready  output  1  sequencer can accept data
tx  output  1  serial line, idle-high
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the final stop bit

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: tx=1, tx_ready=0 during reset, busy=0, frame_done=0, state=IDLE, accumulator=0.
- PHASE_INC = floor(BAUD_RATE * 2^ACC_WIDTH / SYS_CLK_FREQ), computed in 64-bit arithmetic.
  - Elaboration error if PHASE_INC==0 or PHASE_INC >= 2^(ACC_WIDTH-1), i.e. fewer than 2 clocks per bit.
- Baud tick:
  - Accumulator adds PHASE_INC every cycle in any non-IDLE state.
  - tick = carry out of the ACC_WIDTH-bit add (combinational, one cycle).
  - Overflow wraps modulo 2^ACC_WIDTH and keeps the fractional residue, so there is no cumulative drift.
- Accept:
  - tx_ready = (state==IDLE) && !reset.
  - Accept happens when tx_valid && tx_ready.
  - On accept: tx_data latches into a shift register, parity = ^tx_data (XOR PARITY_ODD), accumulator clears to 0, and state goes to START.
- Registered outputs: tx and busy are registered and change on the edge that enters a state.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. Moves to START on accept.
  - START: tx=0. On tick, moves to DATA with bit_cnt=0.
  - DATA: tx = shift[0]. On tick, shift right and increment bit_cnt. At bit_cnt==DATA_BITS-1 with tick, moves to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = parity. On tick, moves to STOP.
  - STOP: tx=1. Counts STOP_BITS ticks, then moves to IDLE.
- Frame completion:
  - frame_done pulses high for exactly one cycle: the first IDLE cycle after the final stop tick.
  - tx_ready is also high in that cycle, so back-to-back accept is allowed there. The stop bit is then extended by exactly 1 clock.
- busy = (state != IDLE).
- tx_valid while busy: ignored. tx_data changes while busy: no effect.
- Reset mid-frame takes effect at the next edge: tx=1, IDLE, no frame_done, byte discarded.

Decomposition:
- Package uart_pkg:
  - uart_tx_state_e enum typedef (IDLE, START, DATA, PARITY, STOP).
  - Function calc_phase_inc(sys_clk, baud, width) returning longint.
- Sub-module baud_tick_gen:
  - Ports: clk, reset, clear, enable, tick.
  - Parameters: ACC_WIDTH, PHASE_INC.
  - Holds the accumulator; tick = carry out when enable.
- The sequencer holds the FSM, shift register, bit and stop counters, and parity.

Test Plan:
- SYS_CLK_FREQ=16, BAUD_RATE=4 (PHASE_INC=2^30, 4 clocks/bit), send 0xA5 with no parity → tx goes low for 4 clocks, then data 1,0,1,0,0,1,0,1 at 4 clocks each, then high 4 clocks. frame_done pulses 40 clocks after the accept edge. tx_ready is low for the whole frame.
- Same clock/baud settings with PARITY_EN=1: even parity on 0xA5 → parity bit 0; with PARITY_ODD=1 → parity bit 1. STOP_BITS=2 → stop high for 8 clocks, frame length 48 clocks.
- Hold tx_valid high with 0x00 then 0xFF → second accept lands on the frame_done cycle. The gap between frames is exactly 1 extra idle-high clock, and there is no lost byte.
- Default parameters (125 MHz, 115200) → bit periods measured over 10 bits are each 1085 or 1086 clocks, and the total frame is 10850 or 10851 clocks.
- Assert reset during DATA bit 3 → tx=1 and busy=0 on the next edge, frame_done stays 0, and a new accept after reset transmits a clean frame.
- tx_valid pulsed mid-frame with different data → ignored; the in-flight byte is transmitted unchanged.
